psum_accumulator: RTL and testbench

- Sits directly downstream of the shift-and-add stage. It consumes one per-filter shifted partial sum per in_valid pulse and accumulates NUM_ACC-style sequences; a sequence is one pulse per (input bit, weight bit) pair.
- Emits the finished per-filter dot-product into an output register with a valid/ready handshake toward the activation/quantisation stage.
- Provides one accumulation lane per filter. All lanes share one FSM and beat counter.

---
 rtl/psum_pkg.sv | 33 +++
 rtl/psum_acc_lane.sv | 40 ++++
 rtl/psum_accumulator.sv | 152 +++++++++++++++
 tb/tb_psum_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared widths, defaults and FSM encoding for the partial-sum accumulator
package psum_pkg;

  localparam int DEF_NUM_ACC        = 64;
  localparam int DEF_MAX_NUM_FILTER = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } psum_state_e;

  // Width of a shifted partial sum as delivered by the shift-and-add stage.
  function automatic int bit_input_shift(input int bit_in);
    return bit_in;
  endfunction

  // Extra bits needed so that num_acc accumulated beats can never overflow.
  function automatic int adc_precision(input int num_acc);
    return $clog2(num_acc);
  endfunction

  // Full lane result width.
  function automatic int bit_acc(input int bit_in, input int num_acc);
    return bit_input_shift(bit_in) + adc_precision(num_acc);
  endfunction

  // Width able to hold any sequence length from 0 to num_acc.
  function automatic int bit_len(input int num_acc);
    return $clog2(num_acc + 1);
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// rtl/psum_acc_lane.sv - one filter lane: sign-extend, load/add select, accumulator register
module psum_acc_lane
  import psum_pkg::*;
#(
  parameter int BIT_IN  = 21,
  parameter int BIT_ACC = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               add,
  input  logic [BIT_IN-1:0]  psum,
  output logic [BIT_ACC-1:0] acc_d,
  output logic [BIT_ACC-1:0] acc_q
);

  logic [BIT_ACC-1:0] psum_ext;

  assign psum_ext = {{(BIT_ACC-BIT_IN){psum[BIT_IN-1]}}, psum};

  // Next accumulator value; the top also uses it to capture the final sum in the same cycle.
  always_comb begin
    acc_d = acc_q;
    if (load) begin
      acc_d = psum_ext;
    end else if (add) begin
      acc_d = acc_q + psum_ext;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - per-filter partial-sum accumulator with valid/ready result register
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int  BIT_IN         = 21,
  parameter int  MAX_NUM_FILTER = DEF_MAX_NUM_FILTER,
  parameter int  NUM_ACC        = DEF_NUM_ACC,
  localparam int BIT_LEN        = bit_len(NUM_ACC),
  localparam int BIT_ACC        = bit_acc(BIT_IN, NUM_ACC)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [MAX_NUM_FILTER*BIT_IN-1:0]  PSUM_IN,
  input  logic [BIT_LEN-1:0]                ACC_LEN,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [MAX_NUM_FILTER*BIT_ACC-1:0] ACC_OUT,
  output logic                              drop_err
);

  psum_state_e state_q, state_d;
  logic [BIT_LEN-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BIT_LEN-1:0] len_q, len_d, len_eff;
  logic accept, out_free;
  logic lane_load, lane_add, last_beat;
  logic out_load_new, out_load_held;
  logic [MAX_NUM_FILTER*BIT_ACC-1:0] acc_d, acc_q;

  assign in_ready = (state_q != S_HOLD);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;
  assign cnt_inc  = cnt_q + BIT_LEN'(1);

  // Sequence length as sampled on the first beat: 0 behaves as 1, oversize clamps to NUM_ACC.
  always_comb begin
    len_eff = ACC_LEN;
    if (ACC_LEN == '0) begin
      len_eff = BIT_LEN'(1);
    end else if (ACC_LEN > BIT_LEN'(NUM_ACC)) begin
      len_eff = BIT_LEN'(NUM_ACC);
    end
  end

  // Next-state, beat counter and lane/output control.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    lane_load     = 1'b0;
    lane_add      = 1'b0;
    last_beat     = 1'b0;
    out_load_new  = 1'b0;
    out_load_held = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lane_load = 1'b1;
          cnt_d     = BIT_LEN'(1);
          len_d     = len_eff;
          if (len_eff == BIT_LEN'(1)) begin
            last_beat = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
          lane_add = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) begin
            last_beat = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_free) begin
          out_load_held = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (last_beat) begin
      cnt_d = '0;
      if (out_free) begin
        out_load_new = 1'b1;
        state_d      = S_IDLE;
      end else begin
        state_d = S_HOLD;
      end
    end
  end

  // FSM, counter and captured length registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Result register: a new result may replace the one being handed off in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ACC_OUT   <= '0;
      out_valid <= 1'b0;
    end else if (out_load_new) begin
      ACC_OUT   <= acc_d;
      out_valid <= 1'b1;
    end else if (out_load_held) begin
      ACC_OUT   <= acc_q;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flag for beats offered while the block was stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      drop_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < MAX_NUM_FILTER; i++) begin : g_lane
    psum_acc_lane #(
      .BIT_IN  (BIT_IN),
      .BIT_ACC (BIT_ACC)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (lane_load),
      .add   (lane_add),
      .psum  (PSUM_IN[i*BIT_IN +: BIT_IN]),
      .acc_d (acc_d[i*BIT_ACC +: BIT_ACC]),
      .acc_q (acc_q[i*BIT_ACC +: BIT_ACC])
    );
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - scoreboard bench for the two-lane partial-sum accumulator
module tb_psum_accumulator;

  localparam int BIT_IN  = 21;
  localparam int NF      = 2;
  localparam int NUM_ACC = 64;
  localparam int BIT_LEN = 7;
  localparam int BIT_ACC = 27;
  localparam int W_OUT   = NF * BIT_ACC;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [NF*BIT_IN-1:0] psum_in;
  logic [BIT_LEN-1:0] acc_len;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  acc_out;
  logic              drop_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [W_OUT-1:0] exp_q[$];
  logic [W_OUT-1:0] mon_exp;

  always #5 clk = ~clk;

  psum_accumulator #(
    .BIT_IN         (BIT_IN),
    .MAX_NUM_FILTER (NF),
    .NUM_ACC        (NUM_ACC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .PSUM_IN   (psum_in),
    .ACC_LEN   (acc_len),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ACC_OUT   (acc_out),
    .drop_err  (drop_err)
  );

  function automatic logic [W_OUT-1:0] pack(input int a, input int b);
    logic [BIT_ACC-1:0] la, lb;
    la = a[BIT_ACC-1:0];
    lb = b[BIT_ACC-1:0];
    return {lb, la};
  endfunction

  // One beat for one cycle; consecutive calls give back-to-back beats.
  task automatic beat(input int v0, input int v1, input int len);
    in_valid = 1'b1;
    psum_in  = {v1[BIT_IN-1:0], v0[BIT_IN-1:0]};
    acc_len  = len[BIT_LEN-1:0];
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got %h, expected no result", acc_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (acc_out !== mon_exp) begin
          n_err++;
          $display("FAIL sb_result: got %h, expected %h", acc_out, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; psum_in = '0; acc_len = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL rst_drop_err: got %b, expected 0", drop_err); end
    n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL rst_acc_out: got %h, expected 0", acc_out); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int vals[4] = '{5, -3, 10, 100};
    int s0 = 0, s1 = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 += vals[i]; s1 -= vals[i];
      beat(vals[i], -vals[i], 4);
    end
    exp_q.push_back(pack(s0, s1));
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
    n_cmp++; if (acc_out !== pack(112, -112)) begin n_err++; $display("FAIL single_value: got %h, expected %h", acc_out, pack(112, -112)); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %b, expected 0", out_valid); end
  endtask

  task automatic test_sign_width();
    int s0 = 0, s1 = 0;
    logic [BIT_ACC-1:0] lane0;
    for (int i = 0; i < NUM_ACC; i++) begin
      s0 += -(1 << 20); s1 += (1 << 20) - 1;
      beat(-(1 << 20), (1 << 20) - 1, NUM_ACC);
    end
    exp_q.push_back(pack(s0, s1));
    lane0 = acc_out[BIT_ACC-1:0];
    n_cmp++; if (lane0 !== 27'h4000000) begin n_err++; $display("FAIL sign_lane0: got %h, expected 4000000", lane0); end
    n_cmp++; if (acc_out !== pack(s0, s1)) begin n_err++; $display("FAIL sign_both: got %h, expected %h", acc_out, pack(s0, s1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(1, -1, 2);
    beat(2, -2, 2);
    exp_q.push_back(pack(3, -3));
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_valid: got %b, expected 1", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_first_ready: got %b, expected 1", in_ready); end
    beat(3, -3, 2);
    beat(4, -4, 2);
    exp_q.push_back(pack(7, -7));
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready: got %b, expected 0", in_ready); end
    n_cmp++; if (acc_out !== pack(3, -3)) begin n_err++; $display("FAIL bp_held_value: got %h, expected %h", acc_out, pack(3, -3)); end
  endtask

  task automatic test_drop();
    beat(9, -9, 2);
    n_cmp++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL drop_flag: got %b, expected 1", drop_err); end
    n_cmp++; if (acc_out !== pack(3, -3)) begin n_err++; $display("FAIL drop_held_value: got %h, expected %h", acc_out, pack(3, -3)); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drop_second_valid: got %b, expected 1", out_valid); end
    n_cmp++; if (acc_out !== pack(7, -7)) begin n_err++; $display("FAIL drop_second_value: got %h, expected %h", acc_out, pack(7, -7)); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drop_drained: got %b, expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready_back: got %b, expected 1", in_ready); end
  endtask

  task automatic test_edge_len();
    out_ready = 1'b1;
    beat(42, -42, 0);
    exp_q.push_back(pack(42, -42));
    n_cmp++; if (acc_out !== pack(42, -42)) begin n_err++; $display("FAIL len0_value: got %h, expected %h", acc_out, pack(42, -42)); end
    beat(7, -7, 1);
    exp_q.push_back(pack(7, -7));
    n_cmp++; if (acc_out !== pack(7, -7)) begin n_err++; $display("FAIL len1_first: got %h, expected %h", acc_out, pack(7, -7)); end
    beat(8, -8, 1);
    exp_q.push_back(pack(8, -8));
    n_cmp++; if (acc_out !== pack(8, -8) || out_valid !== 1'b1) begin n_err++; $display("FAIL len1_second: got %h valid %b, expected %h valid 1", acc_out, out_valid, pack(8, -8)); end
    for (int i = 0; i < NUM_ACC; i++) begin
      beat(1, -1, 100);
      if (i == 0) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL clamp_early: got %b, expected 0", out_valid); end
      end
    end
    exp_q.push_back(pack(NUM_ACC, -NUM_ACC));
    n_cmp++; if (acc_out !== pack(NUM_ACC, -NUM_ACC)) begin n_err++; $display("FAIL clamp_value: got %h, expected %h", acc_out, pack(NUM_ACC, -NUM_ACC)); end
    n_cmp++; if (drop_err !== 1'b1) begin n_err++; $display("FAIL drop_sticky: got %b, expected 1", drop_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat(1, -1, 4);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (acc_out !== '0) begin n_err++; $display("FAIL amid_acc_out: got %h, expected 0", acc_out); end
    n_cmp++; if (drop_err !== 1'b0) begin n_err++; $display("FAIL amid_drop_err: got %b, expected 0", drop_err); end
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL amid_handshake: got valid %b ready %b, expected 0 1", out_valid, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1, -1, 2);
    beat(1, -1, 2);
    exp_q.push_back(pack(2, -2));
    n_cmp++; if (acc_out !== pack(2, -2)) begin n_err++; $display("FAIL amid_restart: got %h, expected %h", acc_out, pack(2, -2)); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_sign_width();
    test_backpressure();
    test_drop();
    test_edge_len();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
